// File: rtl/wb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the regfile write-back path.
// Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    // Source index assignment on the write-back request vector
    localparam int SRC_ALU = 0;
    localparam int SRC_MDU = 1;
    localparam int SRC_LSU = 2;

    // One pending register write
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter_if
// Description : Result-source, regfile-write and forwarding signals of the
//               write-back arbiter. master = surrounding core, slave = arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface wb_write_arbiter_if
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 4
);
    localparam int c_lw = $clog2(DEPTH) + 1;

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [REG_AW*NUM_SRC-1:0] src_waddr;
    logic [DATA_W*NUM_SRC-1:0] src_wdata;

    logic                      we;
    logic [REG_AW-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;

    logic [REG_AW-1:0]         fwd_raddr1;
    logic                      fwd_hit1;
    logic [DATA_W-1:0]         fwd_data1;
    logic [REG_AW-1:0]         fwd_raddr2;
    logic                      fwd_hit2;
    logic [DATA_W-1:0]         fwd_data2;

    logic [c_lw-1:0]           q_level;

    modport master (
        output src_valid, src_waddr, src_wdata, fwd_raddr1, fwd_raddr2,
        input  src_ready, we, waddr, wdata,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, q_level
    );

    modport slave (
        input  src_valid, src_waddr, src_wdata, fwd_raddr1, fwd_raddr2,
        output src_ready, we, waddr, wdata,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, q_level
    );

endinterface : wb_write_arbiter_if
`default_nettype wire

// File: rtl/wb_write_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_grant2
// Description : Round-robin pick of up to two requesters (limited by i_slots),
//               scanning from i_rr_ptr upward with wrap. Reports the grant
//               mask, the first/second winners in scan order and the pointer
//               to use next cycle (one past the last winner).
// Revision    : 1.0  initial release
// ============================================================================
module wb_rr_grant2 #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    input  logic [1:0]         i_slots,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_first_vld,
    output logic [PTR_W-1:0]   o_first_idx,
    output logic               o_second_vld,
    output logic [PTR_W-1:0]   o_second_idx,
    output logic [PTR_W-1:0]   o_next_ptr
);

    logic [1:0] w_cnt;
    int         w_idx;
    int         w_last;

    // Walk requesters in rotated order, granting until the slot budget is spent
    always_comb begin
        o_gnt        = '0;
        o_first_vld  = 1'b0;
        o_first_idx  = '0;
        o_second_vld = 1'b0;
        o_second_idx = '0;
        w_cnt        = 2'd0;
        w_idx        = 0;
        w_last       = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
            if (i_req[w_idx] && (w_cnt < i_slots)) begin
                o_gnt[w_idx] = 1'b1;
                if (w_cnt == 2'd0) begin
                    o_first_vld = 1'b1;
                    o_first_idx = PTR_W'(w_idx);
                end else begin
                    o_second_vld = 1'b1;
                    o_second_idx = PTR_W'(w_idx);
                end
                w_cnt  = w_cnt + 2'd1;
                w_last = w_idx;
            end
        end
        if (w_last >= 0) begin
            o_next_ptr = PTR_W'((w_last + 1) % NUM_REQ);
        end else begin
            o_next_ptr = i_rr_ptr;
        end
    end

endmodule : wb_rr_grant2
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Collects results from NUM_SRC functional units into an
//               in-order write queue (up to 2 pushes/cycle), retires one entry
//               per cycle to the regfile write port and forwards the newest
//               queued value for two read addresses.
// Revision    : 1.0  initial release
// ============================================================================
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_write_arbiter_if.slave bus
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam int c_pw = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Queue state
    wb_entry_t        r_q_mem [DEPTH];
    logic [c_aw-1:0]  r_head;
    logic [c_aw-1:0]  r_tail;
    logic [c_lw-1:0]  r_level;
    logic [c_pw-1:0]  r_rr_ptr;

    // Per-source unpacked views
    logic [REG_AW-1:0]  w_src_addr [NUM_SRC];
    logic [DATA_W-1:0]  w_src_data [NUM_SRC];
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_r0;
    logic [NUM_SRC-1:0] w_gnt;

    logic               w_pop;
    logic [c_lw-1:0]    w_free;
    logic [1:0]         w_slots;
    logic               w_first_vld;
    logic               w_second_vld;
    logic [c_pw-1:0]    w_first_idx;
    logic [c_pw-1:0]    w_second_idx;
    logic [c_pw-1:0]    w_next_ptr;
    logic [c_lw-1:0]    w_npush;
    wb_entry_t          w_ent0;
    wb_entry_t          w_ent1;

    logic               w_hit1;
    logic               w_hit2;
    logic [DATA_W-1:0]  w_fd1;
    logic [DATA_W-1:0]  w_fd2;

    // Writes to r0 are acknowledged immediately and never queued
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_src_addr[gi] = bus.src_waddr[REG_AW*gi +: REG_AW];
            assign w_src_data[gi] = bus.src_wdata[DATA_W*gi +: DATA_W];
            assign w_r0[gi]       = bus.src_valid[gi] && (w_src_addr[gi] == '0);
            assign w_req[gi]      = bus.src_valid[gi] && (w_src_addr[gi] != '0);
        end
    endgenerate

    // The head retires every cycle the queue is non-empty, so its slot is
    // reusable by a push in the same cycle.
    assign w_pop   = (r_level != '0);
    assign w_free  = c_lw'(DEPTH) - r_level + c_lw'(w_pop);
    assign w_slots = (w_free >= c_lw'(2)) ? 2'd2 : w_free[1:0];

    wb_rr_grant2 #(
        .NUM_REQ (NUM_SRC),
        .PTR_W   (c_pw)
    ) u_grant (
        .i_req        (w_req),
        .i_rr_ptr     (r_rr_ptr),
        .i_slots      (w_slots),
        .o_gnt        (w_gnt),
        .o_first_vld  (w_first_vld),
        .o_first_idx  (w_first_idx),
        .o_second_vld (w_second_vld),
        .o_second_idx (w_second_idx),
        .o_next_ptr   (w_next_ptr)
    );

    assign bus.src_ready = w_gnt | w_r0;

    assign w_ent0.addr = w_src_addr[w_first_idx];
    assign w_ent0.data = w_src_data[w_first_idx];
    assign w_ent1.addr = w_src_addr[w_second_idx];
    assign w_ent1.data = w_src_data[w_second_idx];
    assign w_npush     = c_lw'(w_first_vld) + c_lw'(w_second_vld);

    // Queue storage: winners land at tail and tail+1 in grant order
    always_ff @(posedge clk) begin
        if (w_first_vld) begin
            r_q_mem[r_tail] <= w_ent0;
        end
        if (w_second_vld) begin
            r_q_mem[r_tail + c_aw'(1)] <= w_ent1;
        end
    end

    // Pointers, occupancy and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_level  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_head   <= r_head + c_aw'(w_pop);
            r_tail   <= r_tail + c_aw'(w_npush);
            r_level  <= r_level + w_npush - c_lw'(w_pop);
            r_rr_ptr <= w_next_ptr;
        end
    end

    // Retire port: head entry, zeroed when the queue is empty
    assign bus.we      = w_pop;
    assign bus.waddr   = w_pop ? r_q_mem[r_head].addr : '0;
    assign bus.wdata   = w_pop ? r_q_mem[r_head].data : '0;
    assign bus.q_level = r_level;

    // Forwarding: scan head to tail so the newest matching entry wins
    always_comb begin
        w_hit1 = 1'b0;
        w_fd1  = '0;
        w_hit2 = 1'b0;
        w_fd2  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (c_lw'(k) < r_level) begin
                if (r_q_mem[r_head + c_aw'(k)].addr == bus.fwd_raddr1) begin
                    w_hit1 = 1'b1;
                    w_fd1  = r_q_mem[r_head + c_aw'(k)].data;
                end
                if (r_q_mem[r_head + c_aw'(k)].addr == bus.fwd_raddr2) begin
                    w_hit2 = 1'b1;
                    w_fd2  = r_q_mem[r_head + c_aw'(k)].data;
                end
            end
        end
        if (bus.fwd_raddr1 == '0) begin
            w_hit1 = 1'b0;
            w_fd1  = '0;
        end
        if (bus.fwd_raddr2 == '0) begin
            w_hit2 = 1'b0;
            w_fd2  = '0;
        end
    end

    assign bus.fwd_hit1  = w_hit1;
    assign bus.fwd_data1 = w_fd1;
    assign bus.fwd_hit2  = w_hit2;
    assign bus.fwd_data2 = w_fd2;

endmodule : wb_write_arbiter
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_arbiter
// Description : Self-checking bench for wb_write_arbiter: directed vector
//               table, full-queue / reset corner sequences and randomized
//               traffic against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_write_arbiter;
    import wb_pkg::*;

    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_write_arbiter_if #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

    wb_write_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in regfile fed by the arbiter's write port
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (bus.we && bus.waddr != 5'd0) begin
            rf[bus.waddr] <= bus.wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ment_t;

    ment_t       mq[$];
    int          mrr = 0;
    logic [31:0] mrf [32];

    task automatic set_in(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                          input logic [4:0] r1, input logic [4:0] r2);
        bus.src_valid  = v;
        bus.src_waddr  = a;
        bus.src_wdata  = d;
        bus.fwd_raddr1 = r1;
        bus.fwd_raddr2 = r2;
    endtask

    task automatic model_clear();
        mq.delete();
        mrr = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    endtask

    // Compare DUT outputs of the current cycle to the model, then advance the model
    task automatic model_check(input string tag, output logic [2:0] exp_rdy, output logic [2:0] dut_rdy);
        int          lvl;
        int          slots;
        int          last;
        ment_t       pend[$];
        logic        h [2];
        logic [31:0] f [2];
        logic [4:0]  ra;
        lvl   = mq.size();
        slots = DEPTH - lvl + ((lvl != 0) ? 1 : 0);
        if (slots > 2) slots = 2;
        exp_rdy = 3'b000;
        last    = -1;
        for (int k = 0; k < NUM_SRC; k++) begin
            int    i;
            ment_t e;
            i   = (mrr + k) % NUM_SRC;
            e.a = bus.src_waddr[5*i +: 5];
            e.d = bus.src_wdata[32*i +: 32];
            if (bus.src_valid[i]) begin
                if (e.a == 5'd0) begin
                    exp_rdy[i] = 1'b1;
                end else if (pend.size() < slots) begin
                    exp_rdy[i] = 1'b1;
                    pend.push_back(e);
                    last = i;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            ra   = (p == 0) ? bus.fwd_raddr1 : bus.fwd_raddr2;
            h[p] = 1'b0;
            f[p] = 32'h0;
            if (ra != 5'd0) begin
                for (int j = 0; j < lvl; j++) begin
                    if (mq[j].a == ra) begin
                        h[p] = 1'b1;
                        f[p] = mq[j].d;
                    end
                end
            end
        end
        dut_rdy = bus.src_ready;
        chk({tag, "_ready"}, bus.src_ready, exp_rdy);
        chk({tag, "_we"},    bus.we,        (lvl != 0) ? 1 : 0);
        chk({tag, "_waddr"}, bus.waddr,     (lvl != 0) ? mq[0].a : 5'd0);
        chk({tag, "_wdata"}, bus.wdata,     (lvl != 0) ? mq[0].d : 32'h0);
        chk({tag, "_level"}, bus.q_level,   lvl);
        chk({tag, "_hit1"},  bus.fwd_hit1,  h[0]);
        chk({tag, "_data1"}, bus.fwd_data1, f[0]);
        chk({tag, "_hit2"},  bus.fwd_hit2,  h[1]);
        chk({tag, "_data2"}, bus.fwd_data2, f[1]);
        if (lvl != 0) begin
            mrf[mq[0].a] = mq[0].d;
            void'(mq.pop_front());
        end
        foreach (pend[n]) mq.push_back(pend[n]);
        if (last >= 0) mrr = (last + 1) % NUM_SRC;
    endtask

    // One clock cycle: called and returns at posedge+1
    task automatic cycle(input string tag, input logic [2:0] v, input logic [14:0] a,
                         input logic [95:0] d, input logic [4:0] r1, input logic [4:0] r2,
                         output logic [2:0] exp_rdy, output logic [2:0] dut_rdy);
        set_in(v, a, d, r1, r2);
        @(negedge clk);
        model_check(tag, exp_rdy, dut_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(3'b000, 15'h0, 96'h0, 5'd0, 5'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  v;
        logic [14:0] a;
        logic [95:0] d;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [2:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  lvl;
        logic        h1;
        logic [31:0] f1;
        logic        h2;
        logic [31:0] f2;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        logic [2:0]  er;
        logic [2:0]  dr;
        logic [14:0] fa;
        logic [95:0] fdat;
        int          wait_cnt [NUM_SRC];
        int          max_wait;
        logic [2:0]  hv;
        logic [14:0] ha;
        logic [95:0] hd;

        //            v       a                      d                                  r1     r2    rdy     we  wa     wd            lvl  h1 f1            h2 f2
        tbl[0]  = '{3'b000, 15'h0,                 96'h0,                             5'd0, 5'd0, 3'b000, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0};
        tbl[1]  = '{3'b111, {5'd3, 5'd2, 5'd1},    {32'd3, 32'd2, 32'd1},             5'd0, 5'd1, 3'b011, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0};
        tbl[2]  = '{3'b100, {5'd3, 5'd2, 5'd1},    {32'd3, 32'd2, 32'd1},             5'd2, 5'd1, 3'b100, 1, 5'd1, 32'd1,        3'd2, 1, 32'd2,        1, 32'd1};
        tbl[3]  = '{3'b000, 15'h0,                 96'h0,                             5'd3, 5'd1, 3'b000, 1, 5'd2, 32'd2,        3'd2, 1, 32'd3,        0, 32'h0};
        tbl[4]  = '{3'b001, {5'd0, 5'd0, 5'd5},    {32'h0, 32'h0, 32'h1234},          5'd3, 5'd0, 3'b001, 1, 5'd3, 32'd3,        3'd1, 1, 32'd3,        0, 32'h0};
        tbl[5]  = '{3'b100, 15'h0,                 {32'hDEAD, 32'h0, 32'h0},          5'd5, 5'd0, 3'b100, 1, 5'd5, 32'h1234,     3'd1, 1, 32'h1234,     0, 32'h0};
        tbl[6]  = '{3'b000, 15'h0,                 96'h0,                             5'd0, 5'd5, 3'b000, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0};
        tbl[7]  = '{3'b011, {5'd0, 5'd7, 5'd7},    {32'h0, 32'hA, 32'hB},             5'd7, 5'd7, 3'b011, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0};
        tbl[8]  = '{3'b000, 15'h0,                 96'h0,                             5'd7, 5'd0, 3'b000, 1, 5'd7, 32'hA,        3'd2, 1, 32'hB,        0, 32'h0};
        tbl[9]  = '{3'b000, 15'h0,                 96'h0,                             5'd7, 5'd0, 3'b000, 1, 5'd7, 32'hB,        3'd1, 1, 32'hB,        0, 32'h0};
        tbl[10] = '{3'b000, 15'h0,                 96'h0,                             5'd7, 5'd0, 3'b000, 0, 5'd0, 32'h0,        3'd0, 0, 32'h0,        0, 32'h0};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].r1, tbl[i].r2);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), bus.src_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_we", i),    bus.we,        tbl[i].we);
            chk($sformatf("tbl%0d_waddr", i), bus.waddr,     tbl[i].wa);
            chk($sformatf("tbl%0d_wdata", i), bus.wdata,     tbl[i].wd);
            chk($sformatf("tbl%0d_level", i), bus.q_level,   tbl[i].lvl);
            chk($sformatf("tbl%0d_hit1", i),  bus.fwd_hit1,  tbl[i].h1);
            chk($sformatf("tbl%0d_data1", i), bus.fwd_data1, tbl[i].f1);
            chk($sformatf("tbl%0d_hit2", i),  bus.fwd_hit2,  tbl[i].h2);
            chk($sformatf("tbl%0d_data2", i), bus.fwd_data2, tbl[i].f2);
            @(posedge clk);
            #1;
        end
        chk("rf_r0", rf[0], 32'h0);
        chk("rf_r1", rf[1], 32'd1);
        chk("rf_r2", rf[2], 32'd2);
        chk("rf_r3", rf[3], 32'd3);
        chk("rf_r5", rf[5], 32'h1234);
        chk("rf_r7", rf[7], 32'hB);

        // Full queue with all sources continuously requesting
        do_reset();
        fa   = {5'd10, 5'd9, 5'd8};
        fdat = {32'hC000_0000, 32'hB000_0000, 32'hA000_0000};
        for (int i = 0; i < NUM_SRC; i++) wait_cnt[i] = 0;
        max_wait = 0;
        for (int c = 0; c < 15; c++) begin
            cycle("full", 3'b111, fa, fdat, 5'd9, 5'd10, er, dr);
            if (c >= 3) begin
                chk($sformatf("full%0d_onehot", c), dr, 3'b001 << ((c - 3) % 3));
            end
            if (c >= 2) begin
                chk($sformatf("full%0d_level", c), bus.q_level, DEPTH);
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (dr[i]) begin
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
                if (er[i]) fdat[32*i +: 32] = fdat[32*i +: 32] + 32'd1;
            end
        end
        chk("full_max_wait_le2", (max_wait > 2) ? 1 : 0, 0);

        // Reset with three writes still queued
        do_reset();
        cycle("burst0", 3'b011, {5'd0, 5'd11, 5'd10}, {32'h0, 32'h11, 32'h10}, 5'd0, 5'd0, er, dr);
        cycle("burst1", 3'b101, {5'd12, 5'd0, 5'd13}, {32'h12, 32'h0, 32'h13}, 5'd12, 5'd13, er, dr);
        chk("burst_level3", bus.q_level, 3);
        rst = 1'b1;
        set_in(3'b000, 15'h0, 96'h0, 5'd11, 5'd12);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_we", bus.we, 0);
        chk("rst_level", bus.q_level, 0);
        chk("rst_hit1", bus.fwd_hit1, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            cycle("postrst", 3'b000, 15'h0, 96'h0, 5'd11, 5'd13, er, dr);
        end
        chk("rst_rf_r11", rf[11], 32'h0);
        chk("rst_rf_r12", rf[12], 32'h0);
        chk("rst_rf_r13", rf[13], 32'h0);

        // Randomized traffic; sources hold valid/data until accepted
        do_reset();
        hv = 3'b000;
        ha = 15'h0;
        hd = 96'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!hv[i] && ($urandom_range(0, 99) < 60)) begin
                    hv[i]          = 1'b1;
                    ha[5*i +: 5]   = 5'($urandom_range(0, 7));
                    hd[32*i +: 32] = $urandom;
                end
            end
            cycle("rnd", hv, ha, hd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), er, dr);
            hv = hv & ~er;
            if ($urandom_range(0, 399) == 0) do_reset();
        end
        // Drain and compare final register contents
        for (int c = 0; c < 6; c++) begin
            cycle("drain", 3'b000, 15'h0, 96'h0, 5'd0, 5'd0, er, dr);
        end
        for (int r = 1; r < 32; r++) begin
            chk($sformatf("rnd_rf_r%0d", r), rf[r], mrf[r]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_write_arbiter
`default_nettype wire
